microwave_timer_ctrl: RTL and testbench

Parametrised successor to the single-counter microwave block.
- Provides a full cook-timer controller with set, run, pause and done phases.
- Supports saturating add and subtract of time and time-add while cooking.
- Includes a door interlock and a finite done-beep.
- Sits between the debounced button/door inputs and the FND/LED display and magnetron-enable logic.

---
 rtl/microwave_timer_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer controller for the microwave front panel.
// Phases: IDLE (no time set), SET (time being entered), RUN (magnetron on, counting down),
// PAUSE (countdown frozen) and DONE (finite beep, then back to IDLE).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   BTNC         start/pause button (debounced, synchronous)
//   BTNU         add STEP_SEC seconds
//   BTND         subtract STEP_SEC seconds
//   BTNR         cancel/clear
//   i_door_open  door interlock level, 1 = open
//   o_sec        remaining seconds, saturates at MAX_SEC
//   o_running    magnetron enable, high only in RUN
//   o_beep       done buzzer, high only in DONE
//   o_state      IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
//
// Each cycle performs at most one action, chosen by BTNR > door-open > BTNC > BTNU > BTND.
module microwave_timer_ctrl #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned MAX_SEC     = 60,
  parameter int unsigned STEP_SEC    = 10,
  parameter int unsigned BEEP_CYCLES = 300_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         BTNC,
  input  logic                         BTNU,
  input  logic                         BTND,
  input  logic                         BTNR,
  input  logic                         i_door_open,
  output logic [$clog2(MAX_SEC+1)-1:0] o_sec,
  output logic                         o_running,
  output logic                         o_beep,
  output logic [2:0]                   o_state
);

  localparam int unsigned SW     = $clog2(MAX_SEC + 1);
  localparam int unsigned TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW     = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  // A step larger than MAX_SEC saturates identically, and clamping keeps all sums in SW+1 bits.
  localparam int unsigned STEP_C = (STEP_SEC > MAX_SEC) ? MAX_SEC : STEP_SEC;

  localparam logic [SW:0]   LP_MAX       = (SW + 1)'(MAX_SEC);
  localparam logic [SW:0]   LP_STEP      = (SW + 1)'(STEP_C);
  localparam logic [TW-1:0] LP_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] LP_BEEP_LAST = BW'(BEEP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e        r_state;
  logic [SW-1:0] r_sec;
  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_beep_cnt;
  logic          r_btnc_prev;
  logic          r_btnu_prev;
  logic          r_btnd_prev;
  logic          r_btnr_prev;

  state_e        w_state_next;
  logic [SW-1:0] w_sec_next;
  logic [TW-1:0] w_tick_next;
  logic [BW-1:0] w_beep_next;

  logic          w_press_c;
  logic          w_press_u;
  logic          w_press_d;
  logic          w_press_r;
  logic          w_tick;

  logic [SW:0]   w_sec_ext;
  logic [SW:0]   w_sum;
  logic [SW:0]   w_diff;
  logic [SW:0]   w_tick_sum;
  logic [SW-1:0] w_sec_add;
  logic [SW-1:0] w_sec_sub;
  logic [SW-1:0] w_sec_tick_add;

  // Rising-edge detection: previous samples reset to 1 so a button held through reset is ignored.
  assign w_press_c = BTNC & ~r_btnc_prev;
  assign w_press_u = BTNU & ~r_btnu_prev;
  assign w_press_d = BTND & ~r_btnd_prev;
  assign w_press_r = BTNR & ~r_btnr_prev;

  assign w_tick = (r_tick == LP_TICK_LAST);

  // Saturating arithmetic at SW+1 bits; the borrow bit of w_diff flags underflow.
  assign w_sec_ext      = {1'b0, r_sec};
  assign w_sum          = w_sec_ext + LP_STEP;
  assign w_diff         = w_sec_ext - LP_STEP;
  assign w_tick_sum     = w_sec_ext + LP_STEP - (SW + 1)'(1);
  assign w_sec_add      = (w_sum > LP_MAX) ? LP_MAX[SW-1:0] : w_sum[SW-1:0];
  assign w_sec_sub      = w_diff[SW] ? '0 : w_diff[SW-1:0];
  assign w_sec_tick_add = (w_tick_sum > LP_MAX) ? LP_MAX[SW-1:0] : w_tick_sum[SW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_sec       <= '0;
      r_tick      <= '0;
      r_beep_cnt  <= '0;
      r_btnc_prev <= 1'b1;
      r_btnu_prev <= 1'b1;
      r_btnd_prev <= 1'b1;
      r_btnr_prev <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_sec       <= w_sec_next;
      r_tick      <= w_tick_next;
      r_beep_cnt  <= w_beep_next;
      r_btnc_prev <= BTNC;
      r_btnu_prev <= BTNU;
      r_btnd_prev <= BTND;
      r_btnr_prev <= BTNR;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sec_next   = r_sec;
    w_tick_next  = r_tick;
    w_beep_next  = r_beep_cnt;

    unique case (r_state)
      StIdle: begin
        if (w_press_u) begin
          w_sec_next   = SW'(STEP_C);
          w_state_next = StSet;
        end
      end

      // SET and PAUSE differ only in how they were entered; the tick counter is
      // untouched here and cleared on the way into RUN.
      StSet, StPause: begin
        if (w_press_r) begin
          w_sec_next   = '0;
          w_state_next = StIdle;
        end else if (w_press_c) begin
          // Start with the door open is swallowed, not passed down to BTNU/BTND.
          if (!i_door_open) begin
            w_tick_next  = '0;
            w_state_next = StRun;
          end
        end else if (w_press_u) begin
          w_sec_next   = w_sec_add;
          w_state_next = StSet;
          if (r_state == StPause) w_state_next = StPause;
        end else if (w_press_d) begin
          w_sec_next = w_sec_sub;
          if (w_sec_sub == '0) w_state_next = StIdle;
        end
      end

      StRun: begin
        w_tick_next = w_tick ? '0 : r_tick + TW'(1);
        if (w_press_r) begin
          w_sec_next   = '0;
          w_state_next = StIdle;
        end else if (i_door_open || w_press_c) begin
          w_state_next = StPause;
        end else if (w_tick && w_press_u) begin
          w_sec_next = w_sec_tick_add;
        end else if (w_tick) begin
          w_sec_next = r_sec - SW'(1);
          if (r_sec == SW'(1)) begin
            w_beep_next  = '0;
            w_state_next = StDone;
          end
        end else if (w_press_u) begin
          w_sec_next = w_sec_add;
        end
      end

      StDone: begin
        w_sec_next = '0;
        if (w_press_r || i_door_open || w_press_c || w_press_u || w_press_d ||
            (r_beep_cnt == LP_BEEP_LAST)) begin
          w_beep_next  = '0;
          w_state_next = StIdle;
        end else begin
          w_beep_next = r_beep_cnt + BW'(1);
        end
      end

      default: begin
        w_sec_next   = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_sec     = r_sec;
  assign o_state   = r_state;
  assign o_running = (r_state == StRun);
  assign o_beep    = (r_state == StDone);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

  localparam int TD = 10;
  localparam int MX = 60;
  localparam int ST = 10;
  localparam int BP = 5;

  localparam logic [3:0] B_R = 4'b1000;
  localparam logic [3:0] B_C = 4'b0100;
  localparam logic [3:0] B_U = 4'b0010;
  localparam logic [3:0] B_D = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;
  logic       door = 1'b0;
  logic [5:0] sec;
  logic       running;
  logic       beep;
  logic [2:0] state;

  always #5 clk = ~clk;

  microwave_timer_ctrl #(
    .TICK_DIV   (TD),
    .MAX_SEC    (MX),
    .STEP_SEC   (ST),
    .BEEP_CYCLES(BP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .BTNC       (btns[2]),
    .BTNU       (btns[1]),
    .BTND       (btns[0]),
    .BTNR       (btns[3]),
    .i_door_open(door),
    .o_sec      (sec),
    .o_running  (running),
    .o_beep     (beep),
    .o_state    (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: state as a small integer, time in plain seconds, and elapsed
  // cycle counts since entering RUN / DONE.
  int       m_state = 0;
  int       m_sec = 0;
  int       m_run_cyc = 0;
  int       m_done_cyc = 0;
  bit [3:0] m_prev = 4'b1111;
  bit       m_valid = 1'b0;
  bit       pr, pc, pu, pd, tick;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      m_state = 0;
      m_sec = 0;
      m_run_cyc = 0;
      m_done_cyc = 0;
      m_prev = 4'b1111;
    end else begin
      pr = btns[3] && !m_prev[3];
      pc = btns[2] && !m_prev[2];
      pu = btns[1] && !m_prev[1];
      pd = btns[0] && !m_prev[0];
      case (m_state)
        0: if (pu) begin m_sec = min_i(ST, MX); m_state = 1; end
        1, 3: begin
          if (pr) begin m_sec = 0; m_state = 0; end
          else if (pc) begin
            if (!door) begin m_state = 2; m_run_cyc = 0; end
          end
          else if (pu) m_sec = min_i(m_sec + ST, MX);
          else if (pd) begin
            m_sec = max_i(m_sec - ST, 0);
            if (m_sec == 0) m_state = 0;
          end
        end
        2: begin
          m_run_cyc++;
          tick = (m_run_cyc % TD) == 0;
          if (pr) begin m_sec = 0; m_state = 0; end
          else if (door || pc) m_state = 3;
          else if (tick && pu) m_sec = min_i(m_sec - 1 + ST, MX);
          else if (tick) begin
            m_sec = m_sec - 1;
            if (m_sec == 0) begin m_state = 4; m_done_cyc = 0; end
          end
          else if (pu) m_sec = min_i(m_sec + ST, MX);
        end
        4: begin
          m_done_cyc++;
          m_sec = 0;
          if (pr || pc || pu || pd || door || m_done_cyc == BP) m_state = 0;
        end
        default: m_state = 0;
      endcase
      m_prev = btns;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (sec !== 6'(m_sec) || state !== 3'(m_state) || running !== (m_state == 2) ||
          beep !== (m_state == 4)) begin
        n_errors++;
        $display("FAIL model t=%0t got sec=%0d state=%0d run=%0b beep=%0b want sec=%0d state=%0d run=%0b beep=%0b",
                 $time, sec, state, running, beep, m_sec, m_state, m_state == 2, m_state == 4);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    btns = mask;
    @(negedge clk);
    btns = 4'b0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, add and subtract
    cyc(3);
    lit("rst_sec", int'(sec), 0);
    lit("rst_state", int'(state), 0);
    lit("rst_run", int'(running), 0);
    lit("rst_beep", int'(beep), 0);
    reset = 1'b0;
    press(B_U); lit("add1", int'(sec), 10);
    press(B_U); lit("add2", int'(sec), 20);
    press(B_U); lit("add3", int'(sec), 30);
    lit("set_state", int'(state), 1);
    press(B_D); lit("sub1", int'(sec), 20);
    press(B_R); lit("cancel", int'(sec), 0);

    // 2: saturation at MAX_SEC, subtraction to zero, held button
    repeat (8) press(B_U);
    lit("sat_max", int'(sec), 60);
    repeat (6) press(B_D);
    lit("sub_zero", int'(sec), 0);
    lit("sub_idle", int'(state), 0);
    @(negedge clk); btns = B_U;
    cyc(50); btns = 4'b0000;
    lit("held_once", int'(sec), 10);

    // 3: full countdown to DONE and finite beep
    press(B_U);
    press(B_C);
    lit("run_state", int'(state), 2);
    lit("run_on", int'(running), 1);
    cyc(9);  lit("pre_tick", int'(sec), 20);
    cyc(1);  lit("tick1", int'(sec), 19);
    cyc(189); lit("last_sec", int'(sec), 1);
    cyc(1);  lit("done_state", int'(state), 4);
    lit("done_beep", int'(beep), 1);
    cyc(4);  lit("beep_last", int'(beep), 1);
    cyc(1);  lit("beep_end", int'(beep), 0);
    lit("beep_idle", int'(state), 0);

    // 4: door interlock
    repeat (3) press(B_U);
    press(B_C);
    cyc(14); door = 1'b1;
    cyc(1);  lit("door_pause", int'(state), 3);
    lit("door_off", int'(running), 0);
    lit("door_sec", int'(sec), 29);
    cyc(20); lit("frozen", int'(sec), 29);
    press(B_C); lit("open_start", int'(state), 3);
    door = 1'b0;
    cyc(3);
    press(B_C); lit("resume", int'(state), 2);
    cyc(9);  lit("resume_pre", int'(sec), 29);
    cyc(1);  lit("resume_tick", int'(sec), 28);
    press(B_R);

    // 5: tick + add in the same cycle, priority collisions
    press(B_U);
    press(B_C);
    cyc(99); lit("one_left", int'(sec), 1);
    btns = B_U;
    cyc(1);  btns = 4'b0000;
    lit("tick_add", int'(sec), 10);
    lit("tick_add_run", int'(state), 2);
    press(B_R | B_C);
    lit("rc_state", int'(state), 0);
    lit("rc_sec", int'(sec), 0);
    press(B_U); press(B_U);
    press(B_U | B_D);
    lit("ud_sec", int'(sec), 30);
    press(B_R);

    // DONE cut short by a press
    press(B_U);
    press(B_C);
    cyc(100); lit("done2", int'(state), 4);
    press(B_D);
    lit("done_abort", int'(state), 0);
    lit("done_abort_beep", int'(beep), 0);

    // 6: reset mid-run with a button held through it
    press(B_U);
    press(B_C);
    cyc(3);
    btns = B_U; reset = 1'b1;
    cyc(1);
    lit("mid_rst_state", int'(state), 0);
    lit("mid_rst_sec", int'(sec), 0);
    lit("mid_rst_run", int'(running), 0);
    reset = 1'b0;
    cyc(5);  lit("held_rst", int'(sec), 0);
    btns = 4'b0000;
    cyc(1);  btns = B_U;
    cyc(1);  lit("repress", int'(sec), 10);
    btns = 4'b0000;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
